// File: rtl/tl_mem_arbiter.sv
// Round-robin TileLink-UL arbiter that shares one 128-bit burst memory slave
// between NM masters. It grants a whole transaction at a time: every A beat and
// then every D beat. The owner's a_source is restored on the shared D channel.
module tl_mem_arbiter #(
    parameter int NM = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM-1:0]       m_a_valid,
    output logic [NM-1:0]       m_a_ready,
    input  logic [3*NM-1:0]     m_a_opcode,
    input  logic [8*NM-1:0]     m_a_size,
    input  logic [3*NM-1:0]     m_a_source,
    input  logic [32*NM-1:0]    m_a_address,
    input  logic [16*NM-1:0]    m_a_mask,
    input  logic [128*NM-1:0]   m_a_data,
    output logic [NM-1:0]       m_d_valid,
    input  logic [NM-1:0]       m_d_ready,
    output logic [2:0]          m_d_opcode,
    output logic [7:0]          m_d_size,
    output logic [2:0]          m_d_source,
    output logic [127:0]        m_d_data,
    output logic                s_a_valid,
    input  logic                s_a_ready,
    output logic [2:0]          s_a_opcode,
    output logic [7:0]          s_a_size,
    output logic [2:0]          s_a_source,
    output logic [31:0]         s_a_address,
    output logic [15:0]         s_a_mask,
    output logic [127:0]        s_a_data,
    output logic [2:0]          s_a_param,
    output logic                s_a_corrupt,
    input  logic                s_d_valid,
    output logic                s_d_ready,
    input  logic [2:0]          s_d_opcode,
    input  logic [7:0]          s_d_size,
    input  logic [127:0]        s_d_data
);

    localparam int PW = (NM > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABURST = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [2:0]    src_q, src_d;
    logic [8:0]    a_cnt_q, a_cnt_d;
    logic [8:0]    d_cnt_q, d_cnt_d;

    logic [PW-1:0] win;
    logic [PW-1:0] sel;
    logic          a_fire;
    logic          d_fire;

    // Number of 128-bit beats for a 2^size byte transfer, never less than one.
    function automatic logic [8:0] beats(input logic [7:0] size);
        logic [8:0] one;
        logic [8:0] full;
        one  = 9'd1;
        full = one << size;
        if (size < 8'd4) begin
            return 9'd1;
        end
        return full >> 4;
    endfunction

    // Only Put carries a multi-beat A burst.
    function automatic logic [8:0] a_beats(input logic [2:0] op, input logic [7:0] size);
        return ((op == 3'd0) || (op == 3'd1)) ? beats(size) : 9'd1;
    endfunction

    // Only Get returns a multi-beat D burst.
    function automatic logic [8:0] d_beats(input logic [2:0] op, input logic [7:0] size);
        return (op == 3'd4) ? beats(size) : 9'd1;
    endfunction

    // Pick the first requesting master at or after the round-robin pointer.
    always_comb begin
        logic found;
        int   idx;
        win   = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NM; k++) begin
            idx = (int'(rr_ptr_q) + k) % NM;
            if (!found && m_a_valid[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign sel = (state_q == IDLE) ? win : owner_q;

    // Steer the A mux and gate handshakes by state; reset silences every handshake.
    always_comb begin
        m_a_ready   = '0;
        m_d_valid   = '0;
        s_a_valid   = 1'b0;
        s_d_ready   = 1'b0;
        s_a_opcode  = m_a_opcode[sel*3 +: 3];
        s_a_size    = m_a_size[sel*8 +: 8];
        s_a_source  = m_a_source[sel*3 +: 3];
        s_a_address = m_a_address[sel*32 +: 32];
        s_a_mask    = m_a_mask[sel*16 +: 16];
        s_a_data    = m_a_data[sel*128 +: 128];
        case (state_q)
            IDLE: begin
                s_a_valid      = |m_a_valid;
                m_a_ready[win] = s_a_ready;
            end
            ABURST: begin
                s_a_valid          = m_a_valid[owner_q];
                m_a_ready[owner_q] = s_a_ready;
            end
            RESP: begin
                m_d_valid[owner_q] = s_d_valid;
                s_d_ready          = m_d_ready[owner_q];
            end
            default: ;
        endcase
        if (rst) begin
            m_a_ready = '0;
            m_d_valid = '0;
            s_a_valid = 1'b0;
            s_d_ready = 1'b0;
        end
    end

    assign a_fire      = s_a_valid && s_a_ready;
    assign d_fire      = s_d_valid && s_d_ready;
    assign s_a_param   = 3'd0;
    assign s_a_corrupt = 1'b0;
    assign m_d_opcode  = s_d_opcode;
    assign m_d_size    = s_d_size;
    assign m_d_data    = s_d_data;
    assign m_d_source  = src_q;

    // Transaction sequencing: grant, finish the A burst, then drain the D burst.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        src_d    = src_q;
        a_cnt_d  = a_cnt_q;
        d_cnt_d  = d_cnt_q;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    owner_d = win;
                    src_d   = s_a_source;
                    a_cnt_d = a_beats(s_a_opcode, s_a_size) - 9'd1;
                    d_cnt_d = d_beats(s_a_opcode, s_a_size) - 9'd1;
                    state_d = (a_cnt_d != 9'd0) ? ABURST : RESP;
                end
            end
            ABURST: begin
                // a_cnt holds the beats still owed after the grant beat, so the
                // beat that brings it to zero is the last one of the burst.
                if (a_fire) begin
                    a_cnt_d = a_cnt_q - 9'd1;
                    if (a_cnt_q == 9'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (d_fire) begin
                    if (d_cnt_q == 9'd0) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == PW'(NM - 1)) ? '0 : owner_q + 1'b1;
                    end else begin
                        d_cnt_d = d_cnt_q - 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            a_cnt_q  <= 9'd0;
            d_cnt_q  <= 9'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_cnt_q  <= a_cnt_d;
            d_cnt_q  <= d_cnt_d;
        end
    end

    // Owner's source id, only meaningful while a transaction is held.
    always_ff @(posedge clk) begin
        src_q <= src_d;
    end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Scoreboard bench for tl_mem_arbiter: master drivers, a burst memory slave
// model and a monitor that pops expected A/D beats as they fire.
module tb_tl_mem_arbiter;

    localparam int NM = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NM-1:0]       m_a_valid, m_a_ready;
    logic [3*NM-1:0]     m_a_opcode, m_a_source;
    logic [8*NM-1:0]     m_a_size;
    logic [32*NM-1:0]    m_a_address;
    logic [16*NM-1:0]    m_a_mask;
    logic [128*NM-1:0]   m_a_data;
    logic [NM-1:0]       m_d_valid, m_d_ready;
    logic [2:0]          m_d_opcode, m_d_source;
    logic [7:0]          m_d_size;
    logic [127:0]        m_d_data;
    logic                s_a_valid, s_a_ready;
    logic [2:0]          s_a_opcode, s_a_source, s_a_param;
    logic [7:0]          s_a_size;
    logic [31:0]         s_a_address;
    logic [15:0]         s_a_mask;
    logic [127:0]        s_a_data;
    logic                s_a_corrupt;
    logic                s_d_valid, s_d_ready;
    logic [2:0]          s_d_opcode;
    logic [7:0]          s_d_size;
    logic [127:0]        s_d_data;

    typedef struct packed {
        logic [2:0]   op;
        logic [7:0]   size;
        logic [2:0]   src;
        logic [31:0]  addr;
        logic [127:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]   who;
        logic [2:0]   op;
        logic [2:0]   src;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_a_t;

    typedef struct packed {
        logic [1:0]   who;
        logic [2:0]   op;
        logic [7:0]   size;
        logic [2:0]   src;
        logic [127:0] data;
    } exp_d_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [7:0]   size;
        logic [127:0] data;
    } sd_t;

    beat_t  q0[$];
    beat_t  q1[$];
    exp_a_t exp_a[$];
    exp_d_t exp_d[$];
    sd_t    dq[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic           drv_en    = 1'b0;
    logic [NM-1:0]  ovr_valid = '1;
    logic [63:0]    ovr_addr  = {32'h0000_2000, 32'h0000_1000};
    logic           rand_bp   = 1'b0;
    logic           hold_a    = 1'b0;

    tl_mem_arbiter #(.NM(NM)) dut (
        .clk(clk), .rst(rst),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_size(m_a_size), .m_a_source(m_a_source), .m_a_address(m_a_address),
        .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_size(m_d_size), .m_d_source(m_d_source), .m_d_data(m_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address),
        .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_a_param(s_a_param),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_size(s_d_size), .s_d_data(s_d_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] gdat(input logic [31:0] addr, input int k);
        return {addr + 32'(k * 16), 32'(k), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic int sbeats(input logic [7:0] size);
        return (size < 8'd4) ? 1 : ((1 << size) / 16);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // na / nd are the hand-computed A and D beat counts of the transaction.
    task automatic issue(input int m, input logic [2:0] op, input logic [7:0] size,
                         input logic [2:0] src, input logic [31:0] addr,
                         input int na, input int nd);
        beat_t  b;
        exp_a_t ea;
        exp_d_t ed;
        for (int i = 0; i < na; i++) begin
            b.op   = op;
            b.size = size;
            b.src  = src;
            b.addr = addr;
            b.data = (op == 3'd4) ? 128'd0 : {addr, 32'(i), 64'hFEED_0000_0000_BEEF};
            if (m == 0) q0.push_back(b); else q1.push_back(b);
            ea.who  = 2'(m);
            ea.op   = op;
            ea.src  = src;
            ea.addr = addr;
            ea.data = b.data;
            exp_a.push_back(ea);
        end
        for (int k = 0; k < nd; k++) begin
            ed.who  = 2'(m);
            ed.op   = (op == 3'd4) ? 3'd1 : 3'd0;
            ed.size = size;
            ed.src  = src;
            ed.data = (op == 3'd4) ? gdat(addr, k) : 128'd0;
            exp_d.push_back(ed);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((exp_a.size() != 0 || exp_d.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("drain_done", 128'((exp_a.size() == 0) && (exp_d.size() == 0)), 128'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_m_a_ready"}, 128'(m_a_ready), 128'd0);
        chk({tag, "_m_d_valid"}, 128'(m_d_valid), 128'd0);
        chk({tag, "_s_a_valid"}, 128'(s_a_valid), 128'd0);
        chk({tag, "_s_d_ready"}, 128'(s_d_ready), 128'd0);
    endtask

    // Master A drivers and D ready generation.
    initial begin
        logic [NM-1:0] f;
        beat_t         b;
        logic          has;
        m_a_valid = '0; m_a_opcode = '0; m_a_size = '0; m_a_source = '0;
        m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '1;
        forever begin
            @(negedge clk);
            f = m_a_valid & m_a_ready;
            @(posedge clk);
            #1;
            if (f[0] && q0.size() != 0) void'(q0.pop_front());
            if (f[1] && q1.size() != 0) void'(q1.pop_front());
            if (drv_en) begin
                for (int m = 0; m < NM; m++) begin
                    has = (m == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    b   = '0;
                    if (has) b = (m == 0) ? q0[0] : q1[0];
                    m_a_valid[m]            = has;
                    m_a_opcode[m*3 +: 3]    = b.op;
                    m_a_size[m*8 +: 8]      = b.size;
                    m_a_source[m*3 +: 3]    = b.src;
                    m_a_address[m*32 +: 32] = b.addr;
                    m_a_mask[m*16 +: 16]    = 16'hFFFF;
                    m_a_data[m*128 +: 128]  = b.data;
                end
            end else begin
                m_a_valid   = ovr_valid;
                m_a_address = ovr_addr;
            end
            m_d_ready = rand_bp ? NM'($urandom) : '1;
        end
    end

    // Burst memory slave model.
    initial begin
        logic        fa, fd;
        logic [2:0]  ca_op, cur_op;
        logic [7:0]  ca_size, cur_size;
        logic [31:0] ca_addr, cur_addr;
        int          a_left;
        sd_t         d;
        s_a_ready = 1'b1; s_d_valid = 1'b0; s_d_opcode = '0; s_d_size = '0; s_d_data = '0;
        a_left = 0; cur_op = '0; cur_size = '0; cur_addr = '0;
        forever begin
            @(negedge clk);
            fa = s_a_valid && s_a_ready;
            fd = s_d_valid && s_d_ready;
            ca_op = s_a_opcode; ca_size = s_a_size; ca_addr = s_a_address;
            @(posedge clk);
            #1;
            if (rst) begin
                a_left = 0;
                dq.delete();
                s_d_valid = 1'b0;
            end else begin
                if (fa) begin
                    if (a_left == 0) begin
                        cur_op = ca_op; cur_size = ca_size; cur_addr = ca_addr;
                        a_left = ((ca_op == 3'd0) || (ca_op == 3'd1)) ? sbeats(ca_size) : 1;
                    end
                    a_left--;
                    if (a_left == 0) begin
                        if (cur_op == 3'd4) begin
                            for (int k = 0; k < sbeats(cur_size); k++) begin
                                d.op = 3'd1; d.size = cur_size; d.data = gdat(cur_addr, k);
                                dq.push_back(d);
                            end
                        end else begin
                            d.op = 3'd0; d.size = cur_size; d.data = '0;
                            dq.push_back(d);
                        end
                    end
                end
                if (fd) begin
                    if (dq.size() != 0) void'(dq.pop_front());
                    s_d_valid = 1'b0;
                end
                if (!s_d_valid && dq.size() != 0 && (!rand_bp || $urandom_range(0, 1) == 1)) begin
                    s_d_valid  = 1'b1;
                    s_d_opcode = dq[0].op;
                    s_d_size   = dq[0].size;
                    s_d_data   = dq[0].data;
                end
            end
            s_a_ready = hold_a ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: every A or D fire pops the next expected beat.
    initial begin
        exp_a_t        ea;
        exp_d_t        ed;
        logic [NM-1:0] oh;
        forever begin
            @(negedge clk);
            if (s_a_valid && s_a_ready) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_fire", 128'(s_a_address), 128'hFFFF_FFFF_FFFF);
                end else begin
                    ea = exp_a.pop_front();
                    oh = '0;
                    oh[ea.who] = 1'b1;
                    chk("a_grant", 128'(m_a_ready), 128'(oh));
                    chk("a_opcode", 128'(s_a_opcode), 128'(ea.op));
                    chk("a_source", 128'(s_a_source), 128'(ea.src));
                    chk("a_address", 128'(s_a_address), 128'(ea.addr));
                    chk("a_data", s_a_data, ea.data);
                end
            end
            if (|(m_d_valid & m_d_ready)) begin
                if (exp_d.size() == 0) begin
                    chk("d_unexpected_fire", 128'(m_d_valid), 128'd0);
                end else begin
                    ed = exp_d.pop_front();
                    oh = '0;
                    oh[ed.who] = 1'b1;
                    chk("d_route", 128'(m_d_valid), 128'(oh));
                    chk("d_opcode", 128'(m_d_opcode), 128'(ed.op));
                    chk("d_size", 128'(m_d_size), 128'(ed.size));
                    chk("d_source", 128'(m_d_source), 128'(ed.src));
                    chk("d_data", m_d_data, ed.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both masters requesting: every handshake held low.
        repeat (2) @(negedge clk);
        chk_rst_outputs("reset0");
        @(negedge clk);
        chk_rst_outputs("reset1");
        drv_en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Single Get of 64 bytes: one A beat, four D beats to m0.
        issue(0, 3'd4, 8'd6, 3'd3, 32'h0000_0080, 1, 4);
        wait_drain(200);

        // Pointer now at m1: m1's 4-beat PutFull goes first, then m0's Get.
        issue(1, 3'd0, 8'd6, 3'd5, 32'h0000_0200, 4, 1);
        issue(0, 3'd4, 8'd4, 3'd2, 32'h0000_0100, 1, 1);
        wait_drain(200);

        // Small Get (4 bytes) still moves one beat each way.
        issue(1, 3'd4, 8'd2, 3'd1, 32'h0000_0044, 1, 1);
        wait_drain(200);

        // Random backpressure on slave A ready, slave D valid and master D ready.
        rand_bp = 1'b1;
        issue(0, 3'd4, 8'd5, 3'd4, 32'h0000_0300, 1, 2);
        issue(1, 3'd1, 8'd5, 3'd6, 32'h0000_0400, 2, 1);
        issue(0, 3'd0, 8'd4, 3'd7, 32'h0000_0500, 1, 1);
        issue(1, 3'd4, 8'd6, 3'd0, 32'h0000_0600, 1, 4);
        wait_drain(3000);
        rand_bp = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // m0 transaction leaves the pointer at m1.
        issue(0, 3'd4, 8'd3, 3'd0, 32'h0000_0700, 1, 1);
        wait_drain(200);

        // Reset during beat 2 of a 4-beat Put from m1.
        issue(1, 3'd0, 8'd6, 3'd2, 32'h0000_0800, 4, 1);
        for (int c = 0; c < 50 && exp_a.size() != 3; c++) begin
            @(posedge clk);
            #2;
        end
        chk("rst_mid_first_beat", 128'(exp_a.size()), 128'd3);
        rst    = 1'b1;
        drv_en = 1'b0;
        q0.delete(); q1.delete(); exp_a.delete(); exp_d.delete();
        @(negedge clk);
        chk_rst_outputs("rst_mid0");
        @(negedge clk);
        chk_rst_outputs("rst_mid1");
        hold_a = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        // Back in IDLE with pointer at m0: both request, m0's address is muxed.
        chk("post_rst_s_a_valid", 128'(s_a_valid), 128'd1);
        chk("post_rst_winner_addr", 128'(s_a_address), 128'h1000);
        chk("post_rst_m_d_valid", 128'(m_d_valid), 128'd0);
        drv_en = 1'b1;
        hold_a = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Contention: both stream Gets, grants alternate starting at m0.
        for (int i = 0; i < 3; i++) begin
            issue(0, 3'd4, 8'd4, 3'd1, 32'h0000_1000 + 32'(i * 16), 1, 1);
            issue(1, 3'd4, 8'd4, 3'd2, 32'h0000_2000 + 32'(i * 16), 1, 1);
        end
        wait_drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
